// File: rtl/prbs21_rx_checker.sv
`default_nettype none
// ============================================================================
// Module   : prbs21_rx_checker
// Purpose  : Receive-side PRBS-21 (x^21 + x^2 + 1) checker. Slices the signed
//            fixed-point input on each clk_en strobe and self-synchronizes a
//            local PRBS model to the sliced bits. While locked it counts the
//            bits received and the bit errors, and drops lock when a window
//            collects too many errors.
// Ports    : emu_clk  - clock, rising-edge active
//            emu_rst  - asynchronous active-high reset
//            in_      - signed fixed-point received sample (IN_WIDTH bits)
//            thresh   - signed slice threshold (only with SLICE_THRESH_EN)
//            clk_en   - sampling strobe, one bit per high cycle
//            clr      - synchronous clear of bit_cnt / err_cnt
//            rx_bit   - last sliced bit
//            rx_valid - one-cycle pulse when rx_bit updates
//            locked   - high while the checker is in the LOCKED state
//            bit_cnt  - bits checked while locked (saturating)
//            err_cnt  - errors detected while locked (saturating)
// Options  : define SLICE_THRESH_EN to add the thresh port; otherwise the
//            slicer uses the sign bit (threshold 0).
// Revision : 1.0 - initial release
// ============================================================================
module prbs21_rx_checker #(
  parameter int IN_WIDTH   = 18,
  parameter int LOCK_LEN   = 32,
  parameter int WIN_LEN    = 64,
  parameter int ERR_RESYNC = 8
) (
  input  logic                       emu_clk,
  input  logic                       emu_rst,
  input  logic signed [IN_WIDTH-1:0] in_,
`ifdef SLICE_THRESH_EN
  input  logic signed [IN_WIDTH-1:0] thresh,
`endif
  input  logic                       clk_en,
  input  logic                       clr,
  output logic                       rx_bit,
  output logic                       rx_valid,
  output logic                       locked,
  output logic [31:0]                bit_cnt,
  output logic [31:0]                err_cnt
);

  localparam int C_SEED_W  = 5;
  localparam int C_MATCH_W = $clog2(LOCK_LEN + 1);
  localparam int C_WIN_W   = $clog2(WIN_LEN + 1);
  localparam int C_ERR_W   = $clog2(ERR_RESYNC + 1);

  // Last seed strobe index: the history is full after 21 strobes.
  localparam logic [C_SEED_W-1:0]  C_SEED_LAST = C_SEED_W'(20);
  localparam logic [C_MATCH_W-1:0] C_LOCK_LAST = C_MATCH_W'(LOCK_LEN - 1);
  localparam logic [C_WIN_W-1:0]   C_WIN_LAST  = C_WIN_W'(WIN_LEN - 1);
  localparam logic [C_ERR_W-1:0]   C_ERR_LIM   = C_ERR_W'(ERR_RESYNC);
  localparam logic [31:0]          C_CNT_MAX   = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [20:0]          hist_q, hist_d;
  logic [C_SEED_W-1:0]  seed_cnt_q, seed_cnt_d;
  logic [C_MATCH_W-1:0] match_cnt_q, match_cnt_d;
  logic [C_WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [C_ERR_W-1:0]   win_err_q, win_err_d;
  logic [31:0]          bit_cnt_q, bit_cnt_d;
  logic [31:0]          err_cnt_q, err_cnt_d;
  logic                 rx_bit_q;
  logic                 rx_valid_q;

  logic                 w_s;
  logic                 w_p;
  logic                 w_e;
  logic [C_ERR_W-1:0]   w_win_err_inc;

  // Slicer: single signed comparison against the threshold.
`ifdef SLICE_THRESH_EN
  assign w_s = (in_ >= thresh);
`else
  assign w_s = ~in_[IN_WIDTH-1];
`endif

  // hist[0] is the newest bit, so hist[1] is b[n-2] and hist[20] is b[n-21].
  assign w_p           = hist_q[20] ^ hist_q[1];
  assign w_e           = w_s ^ w_p;
  assign w_win_err_inc = win_err_q + C_ERR_W'(w_e);

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    seed_cnt_d  = seed_cnt_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    bit_cnt_d   = bit_cnt_q;
    err_cnt_d   = err_cnt_q;

    if (clk_en) begin
      unique case (state_q)
        ST_SEED: begin
          hist_d = {hist_q[19:0], w_s};
          if (seed_cnt_q == C_SEED_LAST) begin
            seed_cnt_d  = '0;
            match_cnt_d = '0;
            state_d     = ST_VERIFY;
          end else begin
            seed_cnt_d = seed_cnt_q + 1'b1;
          end
        end

        ST_VERIFY: begin
          // Raw data keeps shifting so a failed verify reseeds from live bits.
          hist_d = {hist_q[19:0], w_s};
          if (w_e) begin
            state_d     = ST_SEED;
            seed_cnt_d  = '0;
            match_cnt_d = '0;
          end else if (match_cnt_q == C_LOCK_LAST) begin
            state_d     = ST_LOCKED;
            match_cnt_d = '0;
            win_cnt_d   = '0;
            win_err_d   = '0;
          end else begin
            match_cnt_d = match_cnt_q + 1'b1;
          end
        end

        ST_LOCKED: begin
          // Free-running model: shift in the prediction so bit errors never
          // pollute the reference sequence.
          hist_d = {hist_q[19:0], w_p};
          if (bit_cnt_q != C_CNT_MAX) begin
            bit_cnt_d = bit_cnt_q + 32'd1;
          end
          if (w_e && (err_cnt_q != C_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 32'd1;
          end

          if (w_e && (w_win_err_inc == C_ERR_LIM)) begin
            state_d    = ST_SEED;
            seed_cnt_d = '0;
            win_cnt_d  = '0;
            win_err_d  = '0;
          end else if (win_cnt_q == C_WIN_LAST) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            win_err_d = w_win_err_inc;
          end
        end

        default: begin
          state_d    = ST_SEED;
          seed_cnt_d = '0;
        end
      endcase
    end

    // Clear wins over a same-cycle increment; FSM/window state untouched.
    if (clr) begin
      bit_cnt_d = '0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      state_q     <= ST_SEED;
      hist_q      <= '0;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
      rx_bit_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      bit_cnt_q   <= bit_cnt_d;
      err_cnt_q   <= err_cnt_d;
      rx_valid_q  <= clk_en;
      if (clk_en) begin
        rx_bit_q <= w_s;
      end
    end
  end

  assign rx_bit   = rx_bit_q;
  assign rx_valid = rx_valid_q;
  assign locked   = (state_q == ST_LOCKED);
  assign bit_cnt  = bit_cnt_q;
  assign err_cnt  = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_prbs21_rx_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_prbs21_rx_checker
// Purpose  : Directed self-checking bench for prbs21_rx_checker. Drives a
//            PRBS-21 stream mapped to +/-1.0 (16 fractional bits) with one
//            strobe every 4 clocks and checks lock timing, counters, error
//            windows, clear, inverted data and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prbs21_rx_checker;

  localparam int W = 18;
  localparam logic signed [W-1:0] C_POS = 18'sd65536;   // +1.0
  localparam logic signed [W-1:0] C_NEG = -18'sd65536;  // -1.0
  localparam logic [20:0] C_SEED = 21'h1ABCDE;

  logic                 clk = 1'b0;
  logic                 emu_rst = 1'b1;
  logic signed [W-1:0]  in_ = '0;
`ifdef SLICE_THRESH_EN
  logic signed [W-1:0]  thresh = '0;
`endif
  logic                 clk_en = 1'b0;
  logic                 clr = 1'b0;
  logic                 rx_bit;
  logic                 rx_valid;
  logic                 locked;
  logic [31:0]          bit_cnt;
  logic [31:0]          err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [20:0] g;          // bench PRBS generator state
  logic        sent_s;     // bit the last sample should slice to
  logic        obs_valid;  // rx_valid one cycle after the strobe
  logic        obs_rx;     // rx_bit one cycle after the strobe
  logic        obs_lock;   // locked one cycle after the strobe
  logic        idle_valid; // rx_valid two cycles after the strobe
  int          ls;         // strobes accepted while locked (window position)

  always #5 clk = ~clk;

  prbs21_rx_checker #(
    .IN_WIDTH(W), .LOCK_LEN(32), .WIN_LEN(64), .ERR_RESYNC(8)
  ) dut (
    .emu_clk (clk),
    .emu_rst (emu_rst),
    .in_     (in_),
`ifdef SLICE_THRESH_EN
    .thresh  (thresh),
`endif
    .clk_en  (clk_en),
    .clr     (clr),
    .rx_bit  (rx_bit),
    .rx_valid(rx_valid),
    .locked  (locked),
    .bit_cnt (bit_cnt),
    .err_cnt (err_cnt)
  );

  task automatic reset_dut();
    emu_rst = 1'b1;
    clk_en  = 1'b0;
    clr     = 1'b0;
    repeat (2) @(negedge clk);
    emu_rst = 1'b0;
    g = C_SEED;
  endtask

  // One strobe, then three idle cycles.
  task automatic do_strobe(input logic signed [W-1:0] v, input logic c);
    @(negedge clk);
    in_ = v; clk_en = 1'b1; clr = c;
    @(negedge clk);
    clk_en = 1'b0; clr = 1'b0;
    obs_valid = rx_valid; obs_rx = rx_bit; obs_lock = locked;
    @(negedge clk);
    idle_valid = rx_valid;
    @(negedge clk);
  endtask

  task automatic send_bit(input logic flip, input logic c);
    logic b;
    b = g[20] ^ g[1];
    g = {g[19:0], b};
    sent_s = b ^ flip;
    do_strobe(sent_s ? C_POS : C_NEG, c);
  endtask

  // Feeds clean bits until lock; returns strobe count (0 if bound expired).
  task automatic run_to_lock(output int n);
    int i;
    i = 0;
    while (!locked && i < 200) begin
      send_bit(1'b0, 1'b0);
      i++;
    end
    n = locked ? i : 0;
  endtask

  task automatic test_reset();
    emu_rst = 1'b1;
    #1;
    n_checks++;
    if ({rx_bit, rx_valid, locked} !== 3'b000 || bit_cnt !== 32'd0 || err_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: rx_bit=%b rx_valid=%b locked=%b bit_cnt=%0d err_cnt=%0d, expected all 0",
               rx_bit, rx_valid, locked, bit_cnt, err_cnt);
    end
    reset_dut();
  endtask

  task automatic test_lock();
    int n;
    run_to_lock(n);
    n_checks++;
    if (n !== 53) begin
      n_fail++; $display("FAIL lock_time: strobes=%0d expected 53", n);
    end
    n_checks++;
    if (bit_cnt !== 32'd0) begin
      n_fail++; $display("FAIL bit_cnt_at_lock: got %0d expected 0", bit_cnt);
    end
    for (int i = 0; i < 1000; i++) send_bit(1'b0, 1'b0);
    ls = 1000;
    n_checks++;
    if (bit_cnt !== 32'd1000 || err_cnt !== 32'd0 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL clean_1000: bit_cnt=%0d err_cnt=%0d locked=%b expected 1000/0/1", bit_cnt, err_cnt, locked);
    end
    n_checks++;
    if (obs_valid !== 1'b1 || idle_valid !== 1'b0 || obs_rx !== sent_s) begin
      n_fail++;
      $display("FAIL rx_pulse: valid=%b idle_valid=%b rx_bit=%b expected 1/0/%b", obs_valid, idle_valid, obs_rx, sent_s);
    end
  endtask

  task automatic test_single_error();
    send_bit(1'b1, 1'b0);
    ls++;
    n_checks++;
    if (err_cnt !== 32'd1 || locked !== 1'b1 || obs_rx !== sent_s) begin
      n_fail++;
      $display("FAIL single_err: err_cnt=%0d locked=%b rx_bit=%b expected 1/1/%b", err_cnt, locked, obs_rx, sent_s);
    end
    send_bit(1'b0, 1'b0);
    ls++;
    n_checks++;
    if (err_cnt !== 32'd1 || bit_cnt !== 32'd1002) begin
      n_fail++;
      $display("FAIL after_single_err: err_cnt=%0d bit_cnt=%0d expected 1/1002", err_cnt, bit_cnt);
    end
  endtask

  task automatic test_seven_per_window();
    logic dropped;
    dropped = 1'b0;
    while (ls % 64 != 0) begin send_bit(1'b0, 1'b0); ls++; end
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 64; i++) begin
        send_bit(i < 7, 1'b0);
        ls++;
        if (!locked) dropped = 1'b1;
      end
    end
    n_checks++;
    if (dropped !== 1'b0 || err_cnt !== 32'd15 || bit_cnt !== 32'(ls)) begin
      n_fail++;
      $display("FAIL seven_per_window: dropped=%b err_cnt=%0d bit_cnt=%0d expected 0/15/%0d", dropped, err_cnt, bit_cnt, ls);
    end
  endtask

  task automatic test_resync();
    int n;
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
    n_checks++;
    if (locked !== 1'b1) begin
      n_fail++; $display("FAIL seven_errs_locked: locked=%b expected 1", locked);
    end
    send_bit(1'b1, 1'b0);
    ls += 8;
    n_checks++;
    if (obs_lock !== 1'b0 || err_cnt !== 32'd23 || bit_cnt !== 32'(ls)) begin
      n_fail++;
      $display("FAIL eighth_err: locked=%b err_cnt=%0d bit_cnt=%0d expected 0/23/%0d", obs_lock, err_cnt, bit_cnt, ls);
    end
    run_to_lock(n);
    n_checks++;
    if (n !== 53 || err_cnt !== 32'd23 || bit_cnt !== 32'(ls)) begin
      n_fail++;
      $display("FAIL relock: strobes=%0d err_cnt=%0d bit_cnt=%0d expected 53/23/%0d", n, err_cnt, bit_cnt, ls);
    end
    ls = 0;
  endtask

  task automatic test_clr();
    send_bit(1'b0, 1'b1);
    n_checks++;
    if (bit_cnt !== 32'd0 || err_cnt !== 32'd0 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_strobe: bit_cnt=%0d err_cnt=%0d locked=%b expected 0/0/1", bit_cnt, err_cnt, locked);
    end
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    n_checks++;
    if (bit_cnt !== 32'd2 || err_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL after_clr: bit_cnt=%0d err_cnt=%0d expected 2/1", bit_cnt, err_cnt);
    end
  endtask

  task automatic test_inverted();
    logic ever;
    ever = 1'b0;
    reset_dut();
    for (int i = 0; i < 2000; i++) begin
      send_bit(1'b1, 1'b0);
      if (locked) ever = 1'b1;
    end
    n_checks++;
    if (ever !== 1'b0 || bit_cnt !== 32'd0 || err_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL inverted: ever_locked=%b bit_cnt=%0d err_cnt=%0d expected 0/0/0", ever, bit_cnt, err_cnt);
    end
  endtask

  task automatic test_async_reset();
    int n;
    reset_dut();
    run_to_lock(n);
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0);
    n_checks++;
    if (n !== 53 || bit_cnt !== 32'd5) begin
      n_fail++; $display("FAIL pre_reset: lock strobes=%0d bit_cnt=%0d expected 53/5", n, bit_cnt);
    end
    @(posedge clk);
    #2 emu_rst = 1'b1;
    #1;
    n_checks++;
    if ({rx_bit, rx_valid, locked} !== 3'b000 || bit_cnt !== 32'd0 || err_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: rx_bit=%b rx_valid=%b locked=%b bit_cnt=%0d err_cnt=%0d expected all 0",
               rx_bit, rx_valid, locked, bit_cnt, err_cnt);
    end
    @(negedge clk);
    emu_rst = 1'b0;
    for (int i = 0; i < 10; i++) send_bit(1'b0, 1'b0);
    n_checks++;
    if (locked !== 1'b0 || bit_cnt !== 32'd0) begin
      n_fail++; $display("FAIL post_reset_unlocked: locked=%b bit_cnt=%0d expected 0/0", locked, bit_cnt);
    end
  endtask

`ifdef SLICE_THRESH_EN
  task automatic test_thresh();
    thresh = 18'sd16384;              // +0.25
    do_strobe(18'sd13107, 1'b0);      // +0.2
    n_checks++;
    if (obs_rx !== 1'b0) begin
      n_fail++; $display("FAIL thresh_slice: rx_bit=%b expected 0", obs_rx);
    end
    thresh = '0;
  endtask
`endif

  initial begin
    g = C_SEED;
    sent_s = 1'b0; obs_valid = 1'b0; obs_rx = 1'b0; obs_lock = 1'b0; idle_valid = 1'b0;
    ls = 0;
    test_reset();
    test_lock();
    test_single_error();
    test_seven_per_window();
    test_resync();
    test_clr();
    test_inverted();
    test_async_reset();
`ifdef SLICE_THRESH_EN
    test_thresh();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prbs21_rx_checker.md
Name: prbs21_rx_checker

Overview:
- Receive-side endpoint of the AFE emulation chain.
- Slices the final real-valued (svreal fixed-point) equalizer/nonlinearity output on each emulated-clock strobe (`clk_en`) to recover bits.
- Self-synchronizes a local PRBS-21 model (x^21 + x^2 + 1, same recurrence as the TX generator), then counts received bits and bit errors.
- Sits after the last nonlinearity stage, in the `emu_clk` domain.

Parameters:
- IN_WIDTH, 18, bit width of signed fixed-point input `in_`.
- LOCK_LEN, 32, consecutive correct predictions required to declare lock.
- WIN_LEN, 64, strobe count of the error-monitor window while locked.
- ERR_RESYNC, 8, errors within one window that force loss of lock.

Ports:
- emu_clk  input  1  emulator clock; all state updates on rising edge.
- emu_rst  input  1  reset, asynchronous, active-high.
- in_  input  IN_WIDTH  signed fixed-point received sample.
- clk_en  input  1  sampling strobe; one bit sampled per cycle where high.
- clr  input  1  synchronous clear of `bit_cnt`/`err_cnt`.
- rx_bit  output  1  last sliced bit.
- rx_valid  output  1  one-cycle pulse when `rx_bit` is updated.
- locked  output  1  high in LOCKED state.
- bit_cnt  output  32  bits checked while locked, saturating.
- err_cnt  output  32  errors detected while locked, saturating.

Behaviour:
- Reset (async):
  - outputs: `rx_bit`=0, `rx_valid`=0, `locked`=0, `bit_cnt`=0, `err_cnt`=0.
  - internal state: history register `hist[20:0]`=0, state=SEED, all internal counters 0.
- Slicing:
  - s = 1 when `in_` >= 0 (sign bit clear), else 0.
  - Polarity matches TX mapping: 1 -> +1.0, 0 -> -1.0.
- Sampling:
  - On each `clk_en`=1 cycle, `hist` <= {`hist[19:0]`, s}.
  - `rx_bit` <= s and `rx_valid` <= 1, both registered, visible the cycle after the strobe.
  - `rx_valid`=0 otherwise.
- Prediction: p = `hist[20]` ^ `hist[1]`, evaluated before the shift. Error e = (s != p).
- FSM (advances only on strobes):
  - SEED: count strobes; after 21 strobes `hist` is fully loaded -> VERIFY with match count 0.
  - VERIFY: e=0 increments match count; at LOCK_LEN matches -> LOCKED. e=1 -> SEED, all seed/match counts cleared; `hist` keeps shifting the raw data.
  - LOCKED:
    - The local model free-runs: `hist` shifts in p, not s, so errors do not corrupt the reference.
    - Each strobe: `bit_cnt`+1; if e then `err_cnt`+1 and window error count+1.
    - Window counter wraps at WIN_LEN strobes, clearing window errors.
    - When window errors reach ERR_RESYNC, that error is still counted, then next state is SEED and `locked` deasserts the following cycle.
  - `locked` is registered, high exactly while state=LOCKED.
- Counters saturate at 2^32-1; no wrap.
- `clr`:
  - Zeroes `bit_cnt`/`err_cnt` next cycle.
  - Has precedence over a same-cycle strobe increment; that strobe's counts are dropped.
  - Does not affect FSM, `hist`, or window state.
- Strobe with no `clk_en`: no state change.
- Async reset mid-operation returns everything to reset values immediately.
- Inverted-polarity data never locks: every prediction mismatches, so the FSM cycles SEED/VERIFY.
- Area: one comparator path and no multipliers; DSP-free.

Optional Feature:
- Macro: SLICE_THRESH_EN.
- Defined:
  - Adds port `thresh`, input, IN_WIDTH, signed, same fixed-point format as `in_`.
  - Slice rule becomes s = (`in_` >= `thresh`), signed compare.
- Undefined: no `thresh` port; threshold fixed at 0 (sign-bit slice).

Test Plan:
- Reset: assert `emu_rst` asynchronously mid-cycle -> all outputs 0 immediately; `locked`=0 until relock.
- Clean PRBS-21 via TX mapping (±1.0 encoded), `clk_en` every 4 cycles -> `locked` rises after exactly 21+32=53 strobes. After 1000 further strobes: `bit_cnt`=1000, `err_cnt`=0.
- While locked, flip the sign of one sample -> `err_cnt`=1, `locked` stays 1, and the next sample shows no error, because the model free-runs.
- While locked, flip 8 samples within one 64-strobe window -> `err_cnt`=8, `locked` drops the cycle after the 8th error, then relocks after 53 clean strobes. Flipping 7 per window never drops lock.
- Inverted data (all samples negated) for 2000 strobes -> `locked` never asserts; `bit_cnt`=0.
- `clr` pulsed on the same cycle as a locked strobe -> `bit_cnt`/`err_cnt` read 0, then count from the next strobe; `locked` unaffected. With SLICE_THRESH_EN, `thresh`=+0.25 and `in_`=+0.2 -> `rx_bit`=0.
